// File: rtl/disp_write_sched.sv
// Round-robin write scheduler for the character display buffer: arbitrates two
// requesters and turns each accepted write into a registered setup/pulse/hold strobe.
module disp_write_sched #(
  parameter int unsigned            ASCII_WIDTH  = 8,
  parameter int unsigned            COLOR_WIDTH  = 4,
  parameter int unsigned            SETUP_CYC    = 2,
  parameter int unsigned            PULSE_CYC    = 2,
  parameter int unsigned            HOLD_CYC     = 2,
  parameter bit                     CLR_ON_RESET = 1'b1,
  parameter logic [COLOR_WIDTH-1:0] DEF_F        = COLOR_WIDTH'(4'hF),
  parameter logic [COLOR_WIDTH-1:0] DEF_B        = COLOR_WIDTH'(4'h0)
) (
  input  logic                   clk_pix,
  input  logic                   rst,
  input  logic                   a_valid,
  input  logic [ASCII_WIDTH-1:0] a_ascii,
  input  logic [COLOR_WIDTH-1:0] a_colF,
  input  logic [COLOR_WIDTH-1:0] a_colB,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [ASCII_WIDTH-1:0] b_ascii,
  input  logic [COLOR_WIDTH-1:0] b_colF,
  input  logic [COLOR_WIDTH-1:0] b_colB,
  output logic                   b_ready,
  output logic                   dataReady,
  output logic [ASCII_WIDTH-1:0] ascii,
  output logic [COLOR_WIDTH-1:0] colorIndexF,
  output logic [COLOR_WIDTH-1:0] colorIndexB,
  output logic                   busy
);

  localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]       SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0]       PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]       HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [ASCII_WIDTH-1:0] CLR_CODE = ASCII_WIDTH'(8'h02);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ptr_b_q, ptr_b_d;
  logic                   data_ready_q, data_ready_d;
  logic [ASCII_WIDTH-1:0] ascii_q, ascii_d;
  logic [COLOR_WIDTH-1:0] col_f_q, col_f_d;
  logic [COLOR_WIDTH-1:0] col_b_q, col_b_d;
  logic                   busy_q, busy_d;
  logic                   grant_a_c;

  // A wins when it alone is valid, or on a tie (both/neither) when B was served last
  assign grant_a_c = (a_valid && !b_valid) || (!(a_valid ^ b_valid) && ptr_b_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_b_d      = ptr_b_q;
    data_ready_d = data_ready_q;
    ascii_d      = ascii_q;
    col_f_d      = col_f_q;
    col_b_d      = col_b_q;
    a_ready      = 1'b0;
    b_ready      = 1'b0;

    case (state_q)
      ST_INIT: begin
        ascii_d = CLR_CODE;
        col_f_d = DEF_F;
        col_b_d = DEF_B;
        cnt_d   = SETUP_LD;
        state_d = ST_SETUP;
      end
      ST_IDLE: begin
        a_ready = grant_a_c;
        b_ready = !grant_a_c;
        if (a_valid && grant_a_c) begin
          ascii_d = a_ascii;
          col_f_d = a_colF;
          col_b_d = a_colB;
          ptr_b_d = 1'b0;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
        end else if (b_valid && !grant_a_c) begin
          ascii_d = b_ascii;
          col_f_d = b_colF;
          col_b_d = b_colB;
          ptr_b_d = 1'b1;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          data_ready_d = 1'b1;
          cnt_d        = PULSE_LD;
          state_d      = ST_HIGH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          data_ready_d = 1'b0;
          cnt_d        = HOLD_LD;
          state_d      = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        data_ready_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Reset aborts any write in flight; the strobe drops on the reset edge
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state_q      <= CLR_ON_RESET ? ST_INIT : ST_IDLE;
      cnt_q        <= '0;
      ptr_b_q      <= 1'b1;
      data_ready_q <= 1'b0;
      ascii_q      <= '0;
      col_f_q      <= '0;
      col_b_q      <= '0;
      busy_q       <= CLR_ON_RESET;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_b_q      <= ptr_b_d;
      data_ready_q <= data_ready_d;
      ascii_q      <= ascii_d;
      col_f_q      <= col_f_d;
      col_b_q      <= col_b_d;
      busy_q       <= busy_d;
    end
  end

  assign dataReady   = data_ready_q;
  assign ascii       = ascii_q;
  assign colorIndexF = col_f_q;
  assign colorIndexB = col_b_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_disp_write_sched.sv
// Bench for disp_write_sched: default instance plus a 1/1/1 no-clear instance, each
// checked every cycle against a transaction-level timing model, with directed pins.
module tb_disp_write_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2], a_valid[2], b_valid[2], a_ready[2], b_ready[2], dr[2], busy[2];
  logic [7:0] a_ascii[2], b_ascii[2], ascii_o[2];
  logic [3:0] a_f[2], a_b[2], b_f[2], b_b[2], cf_o[2], cb_o[2];

  disp_write_sched dut0 (
    .clk_pix(clk), .rst(rst[0]),
    .a_valid(a_valid[0]), .a_ascii(a_ascii[0]), .a_colF(a_f[0]), .a_colB(a_b[0]), .a_ready(a_ready[0]),
    .b_valid(b_valid[0]), .b_ascii(b_ascii[0]), .b_colF(b_f[0]), .b_colB(b_b[0]), .b_ready(b_ready[0]),
    .dataReady(dr[0]), .ascii(ascii_o[0]), .colorIndexF(cf_o[0]), .colorIndexB(cb_o[0]), .busy(busy[0])
  );

  disp_write_sched #(
    .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1), .CLR_ON_RESET(1'b0)
  ) dut1 (
    .clk_pix(clk), .rst(rst[1]),
    .a_valid(a_valid[1]), .a_ascii(a_ascii[1]), .a_colF(a_f[1]), .a_colB(a_b[1]), .a_ready(a_ready[1]),
    .b_valid(b_valid[1]), .b_ascii(b_ascii[1]), .b_colF(b_f[1]), .b_colB(b_b[1]), .b_ready(b_ready[1]),
    .dataReady(dr[1]), .ascii(ascii_o[1]), .colorIndexF(cf_o[1]), .colorIndexB(cb_o[1]), .busy(busy[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = -1;

  // Model parameters per instance
  int S[2]   = '{2, 1};
  int P[2]   = '{2, 1};
  int H[2]   = '{2, 1};
  bit CLR[2] = '{1'b1, 1'b0};
  int dir_end[2] = '{62, 8};

  // Model state: last transfer cycle, first idle cycle, expected visible data
  int         tw[2]     = '{-1000, -1000};
  int         free_c[2] = '{0, 0};
  bit         last_b[2], started[2], init_pend[2], acc_a[2], acc_b[2];
  logic [7:0] e_ascii[2];
  logic [3:0] e_f[2], e_b[2];

  int rises  = 0;
  bit prev_dr0 = 1'b0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", name, k, cyc, act, exp);
    end
  endtask

  task automatic drive(input int k);
    if (cyc < dir_end[k]) begin
      if (k == 0) begin
        rst[0]     = (cyc < 2) || (cyc == 54);
        a_valid[0] = (cyc == 9) || (cyc >= 16 && cyc < 44);
        a_ascii[0] = 8'h41; a_f[0] = 4'h1; a_b[0] = 4'h2;
        b_valid[0] = (cyc >= 16 && cyc < 44) || (cyc == 44) || (cyc == 51);
        b_ascii[0] = (cyc < 44) ? 8'h42 : (cyc < 51) ? 8'h7F : 8'h11;
        b_f[0] = 4'h3; b_b[0] = 4'h5;
      end else begin
        rst[1]     = (cyc < 2);
        a_valid[1] = (cyc == 3);
        a_ascii[1] = 8'h41; a_f[1] = 4'h6; a_b[1] = 4'h9;
        b_valid[1] = 1'b0;
      end
    end else begin
      rst[k] = ($urandom_range(149) == 0);
      if (!(a_valid[k] && !acc_a[k])) begin
        a_valid[k] = ($urandom_range(2) != 0);
        a_ascii[k] = 8'($urandom); a_f[k] = 4'($urandom); a_b[k] = 4'($urandom);
      end
      if (!(b_valid[k] && !acc_b[k])) begin
        b_valid[k] = ($urandom_range(2) != 0);
        b_ascii[k] = 8'($urandom); b_f[k] = 4'($urandom); b_b[k] = 4'($urandom);
      end
    end
    acc_a[k] = 1'b0;
    acc_b[k] = 1'b0;
  endtask

  task automatic model_step(input int k);
    bit idle, ga, e_dr;
    idle = (cyc >= free_c[k]);
    if (a_valid[k] && !b_valid[k])      ga = 1'b1;
    else if (b_valid[k] && !a_valid[k]) ga = 1'b0;
    else                                ga = last_b[k];
    e_dr = (cyc > tw[k] + S[k]) && (cyc <= tw[k] + S[k] + P[k]);
    if (started[k]) begin
      chk("a_ready", k, a_ready[k], idle && ga);
      chk("b_ready", k, b_ready[k], idle && !ga);
      chk("dataReady", k, dr[k], e_dr);
      chk("busy", k, busy[k], !idle);
      chk("ascii", k, ascii_o[k], e_ascii[k]);
      chk("colorF", k, cf_o[k], e_f[k]);
      chk("colorB", k, cb_o[k], e_b[k]);
    end
    if (rst[k]) begin
      started[k] = 1'b1;
      e_ascii[k] = 8'h00; e_f[k] = 4'h0; e_b[k] = 4'h0;
      last_b[k]  = 1'b1;
      if (CLR[k]) begin
        tw[k] = cyc + 1; free_c[k] = cyc + 2 + S[k] + P[k] + H[k]; init_pend[k] = 1'b1;
      end else begin
        tw[k] = -1000; free_c[k] = cyc + 1; init_pend[k] = 1'b0;
      end
    end else if (started[k]) begin
      if (init_pend[k]) begin
        e_ascii[k] = 8'h02; e_f[k] = 4'hF; e_b[k] = 4'h0; init_pend[k] = 1'b0;
      end else if (idle && ga && a_valid[k]) begin
        e_ascii[k] = a_ascii[k]; e_f[k] = a_f[k]; e_b[k] = a_b[k];
        last_b[k] = 1'b0; tw[k] = cyc; free_c[k] = cyc + S[k] + P[k] + H[k] + 1; acc_a[k] = 1'b1;
      end else if (idle && !ga && b_valid[k]) begin
        e_ascii[k] = b_ascii[k]; e_f[k] = b_f[k]; e_b[k] = b_b[k];
        last_b[k] = 1'b1; tw[k] = cyc; free_c[k] = cyc + S[k] + P[k] + H[k] + 1; acc_b[k] = 1'b1;
      end
    end
  endtask

  // Hand-computed expectations pinning the model on the directed prefix
  task automatic literal_checks();
    case (cyc)
      2: begin
        chk("clr_init_ascii", 0, ascii_o[0], 8'h00);
        chk("clr_init_busy", 0, busy[0], 1);
        chk("clr_init_ardy", 0, a_ready[0], 0);
        chk("corner_idle_busy", 1, busy[1], 0);
        chk("corner_idle_ardy", 1, a_ready[1], 1);
      end
      3: begin
        chk("clr_ascii", 0, ascii_o[0], 8'h02);
        chk("clr_colF", 0, cf_o[0], 4'hF);
        chk("clr_colB", 0, cb_o[0], 4'h0);
      end
      4: begin
        chk("clr_dr_pre", 0, dr[0], 0);
        chk("corner_ascii", 1, ascii_o[1], 8'h41);
        chk("corner_dr_pre", 1, dr[1], 0);
      end
      5: begin chk("clr_dr_hi1", 0, dr[0], 1); chk("corner_dr_hi", 1, dr[1], 1); end
      6: begin chk("clr_dr_hi2", 0, dr[0], 1); chk("corner_dr_post", 1, dr[1], 0); end
      7: begin chk("clr_dr_low", 0, dr[0], 0); chk("corner_idle_again", 1, busy[1], 0); end
      8: chk("clr_busy_last", 0, busy[0], 1);
      9: begin chk("clr_busy_fall", 0, busy[0], 0); chk("a_write_ready", 0, a_ready[0], 1); end
      10: chk("a_write_ascii", 0, ascii_o[0], 8'h41);
      12: chk("a_write_dr_t3", 0, dr[0], 1);
      13: chk("a_write_dr_t4", 0, dr[0], 1);
      14: chk("a_write_dr_t5", 0, dr[0], 0);
      15: chk("a_write_hold_ascii", 0, ascii_o[0], 8'h41);
      16: chk("contend_grant_b", 0, b_ready[0], 1);
      23: chk("contend_grant_a", 0, a_ready[0], 1);
      45: begin
        chk("contend_rises", 0, rises, 4);
        chk("pass_7f", 0, ascii_o[0], 8'h7F);
        chk("pass_colF", 0, cf_o[0], 4'h3);
        chk("pass_colB", 0, cb_o[0], 4'h5);
      end
      52: chk("pass_11", 0, ascii_o[0], 8'h11);
      54: chk("midrst_dr_before", 0, dr[0], 1);
      55: begin chk("midrst_dr_drop", 0, dr[0], 0); chk("midrst_ascii", 0, ascii_o[0], 8'h00); end
      56: chk("midrst_clr_ascii", 0, ascii_o[0], 8'h02);
      58: chk("midrst_clr_dr", 0, dr[0], 1);
      60: chk("midrst_clr_dr_low", 0, dr[0], 0);
      62: chk("midrst_idle", 0, busy[0], 0);
      default: ;
    endcase
    if (cyc >= 17 && cyc <= 44 && dr[0] && !prev_dr0) rises++;
    prev_dr0 = dr[0];
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; a_valid[k] = 1'b0; b_valid[k] = 1'b0;
      a_ascii[k] = '0; a_f[k] = '0; a_b[k] = '0;
      b_ascii[k] = '0; b_f[k] = '0; b_b[k] = '0;
    end
    repeat (3000) begin
      @(posedge clk);
      cyc++;
      #1;
      for (int k = 0; k < 2; k++) drive(k);
      @(negedge clk);
      literal_checks();
      for (int k = 0; k < 2; k++) model_step(k);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
